// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register.
// Consumed by pipe_stage_reg (optional skid mode: PIPE_STAGE_SKID_EN).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 12;

    // All-zero control word: no register write, no memory access.
    localparam logic [CTRL_W_DEF-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry {ctrl,data}: load-enable plus synchronous clear,
// cleared asynchronously by the active-low reset.
module pipe_entry_reg #(
    parameter int unsigned W = 44
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush. Define PIPE_STAGE_SKID_EN
// for a two-entry skid buffer with registered in_ready; default is one entry.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int unsigned ENTRY_W = CTRL_W + DATA_W;

    stage_state_t         state, state_nxt;
    logic                 accept, drain;
    logic [ENTRY_W-1:0]   head_q;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = out_valid ? head_q[ENTRY_W-1 -: CTRL_W] : CTRL_W'(BUBBLE);
    assign out_data  = head_q[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

`ifdef PIPE_STAGE_SKID_EN

    logic               ready_q;
    logic               head_load, skid_load, head_from_skid;
    logic [ENTRY_W-1:0] head_d, skid_q;

    // Register resets to 1 so the stage is ready the moment reset releases;
    // the reset gate keeps in_ready low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ready_q <= 1'b1;
        else
            ready_q <= (state_nxt != TWO);
    end

    assign in_ready = reset && ready_q;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nxt = ONE;
                    head_load = 1'b1;
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_nxt = TWO;
                        skid_load = 1'b1;
                    end else if (accept && drain) begin
                        head_load = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (drain) begin
                    state_nxt      = ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : {in_ctrl, in_data};

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .clear (flush),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (flush),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q)
    );

`else

    assign in_ready  = reset && ((state == EMPTY) || out_ready);
    assign occupancy = {1'b0, (state != EMPTY)};

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = ONE;
        else if (drain)
            state_nxt = EMPTY;
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (accept && !flush),
        .clear (flush),
        .d     ({in_ctrl, in_data}),
        .q     (head_q)
    );

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; skid-specific checks are enabled
// when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n_rel = 0;
    logic [CW+DW-1:0] sb[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive after the falling edge, score the handshake just before the
    // rising edge, return 1 time unit after it.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        logic [CW+DW-1:0] e;
        logic             exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #4;
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (occupancy != 2'd2);
`else
        exp_rdy = !out_valid || out_ready;
`endif
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (!out_valid)
            chk("bubble_ctrl", {52'd0, out_ctrl}, 64'd0);
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_rel++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_ctrl", {52'd0, out_ctrl}, {52'd0, e[CW+DW-1:DW]});
                    chk("out_data", {32'd0, out_data}, {32'd0, e[DW-1:0]});
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #2;
        chk("rst_occ", {62'd0, occupancy}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ctrl", {52'd0, out_ctrl}, 64'd0);
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        #10;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // single entry appears one edge later
        step(1'b1, 12'h0A5, 32'h1234_5678, 1'b1, 1'b0);
        chk("first_valid", {63'd0, out_valid}, 64'd1);
        chk("first_ctrl", {52'd0, out_ctrl}, 64'h0A5);
        chk("first_data", {32'd0, out_data}, 64'h1234_5678);

        // back-to-back stream, no bubbles
        n_rel = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
            chk("stream_occ_le1", {63'd0, (occupancy <= 2'd1)}, 64'd1);
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_releases", 64'(n_rel), 64'd9);
        chk("stream_empty", {62'd0, occupancy}, 64'd0);

`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, 12'h00A, 32'hA, 1'b0, 1'b0);
        step(1'b1, 12'h00B, 32'hB, 1'b0, 1'b0);
        chk("skid_occ2", {62'd0, occupancy}, 64'd2);
        chk("skid_not_ready", {63'd0, in_ready}, 64'd0);
        chk("skid_hold_a", {32'd0, out_data}, 64'hA);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("skid_occ1", {62'd0, occupancy}, 64'd1);
        chk("skid_next_b", {32'd0, out_data}, 64'hB);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("skid_drained", {62'd0, occupancy}, 64'd0);
`else
        step(1'b1, 12'h00A, 32'hA, 1'b0, 1'b0);
        step(1'b1, 12'h00B, 32'hB, 1'b0, 1'b0);
        chk("stall_not_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_hold_a", {32'd0, out_data}, 64'hA);
        step(1'b1, 12'h00C, 32'hC, 1'b1, 1'b0);
        chk("replace_valid", {63'd0, out_valid}, 64'd1);
        chk("replace_c", {32'd0, out_data}, 64'hC);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("replace_drained", {62'd0, occupancy}, 64'd0);
`endif

        // flush squashes held and incoming entries
        step(1'b1, 12'h00A, 32'hA, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, 12'h00B, 32'hB, 1'b0, 1'b0);
        chk("pre_flush_occ", {62'd0, occupancy}, 64'd2);
`endif
        step(1'b1, 12'h00C, 32'hC, 1'b0, 1'b1);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ctrl", {52'd0, out_ctrl}, 64'd0);
        n_rel = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);
        end
        chk("flush_no_emit", 64'(n_rel), 64'd0);

        // asynchronous reset mid-stall
        step(1'b1, 12'h00D, 32'hD, 1'b0, 1'b0);
        chk("pre_rst_occ", {62'd0, occupancy}, 64'd1);
        #3;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("async_valid", {63'd0, out_valid}, 64'd0);
        chk("async_data", {32'd0, out_data}, 64'd0);
        chk("async_occ", {62'd0, occupancy}, 64'd0);
        chk("async_in_ready", {63'd0, in_ready}, 64'd0);
        sb.delete();
        #2;
        reset = 1'b1;
        #1;
        chk("rerst_ready", {63'd0, in_ready}, 64'd1);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), CW'($urandom_range(1, 4095)), DW'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
`ifndef PIPE_STAGE_SKID_EN
            chk("single_occ", {63'd0, (occupancy != 2'd2)}, 64'd1);
`endif
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_occ", {62'd0, occupancy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
